// File: rtl/frame_pkg.sv
// Shared types for the frame switch: FSM state encoding and the
// helper that sizes buffer-index fields from the buffer count.
package frame_pkg;

    typedef enum logic [1:0] {
        ST_BLANK      = 2'd0,
        ST_RUN        = 2'd1,
        ST_PEND_SWAP  = 2'd2,
        ST_PEND_BLANK = 2'd3
    } state_e;

    function automatic int buf_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_pix_sel.sv
// Per-pixel source select: picks the active buffer, the blank value
// or (when FRAME_SWITCH_TPG_EN is defined) the test-pattern pixel.
// Ports: buf_data/sel/blanked in, pix out (combinational);
// tpg_on/tpg_pix exist only with FRAME_SWITCH_TPG_EN.
module frame_pix_sel
    import frame_pkg::*;
#(
    parameter int               PIX_W     = 8,
    parameter int               NUM_BUF   = 2,
    parameter logic [PIX_W-1:0] BLANK_VAL = '0,
    parameter int               IDX_W     = 1
) (
    input  logic [NUM_BUF*PIX_W-1:0] buf_data,
    input  logic [IDX_W-1:0]         sel,
    input  logic                     blanked,
`ifdef FRAME_SWITCH_TPG_EN
    input  logic                     tpg_on,
    input  logic [PIX_W-1:0]         tpg_pix,
`endif
    output logic [PIX_W-1:0]         pix
);

    always_comb begin
        pix = BLANK_VAL;
        if (!blanked) begin
            for (int k = 0; k < NUM_BUF; k++) begin
                if (int'(sel) == k) begin
                    pix = buf_data[k*PIX_W +: PIX_W];
                end
            end
`ifdef FRAME_SWITCH_TPG_EN
            if (tpg_on) begin
                pix = tpg_pix;
            end
`endif
        end
    end

endmodule

// File: rtl/frame_switch.sv
// Frame-boundary-synchronous source switch for a pixel stream.
// Ports: Clk, Rst_n (sync, active-low); BufData/PixValid/FrameEnd
// pixel input; SwapReq/SwapBuf/BlankReq control; FrameIn/FrameValid
// registered output; ActiveBuf/Blanked status; SwapAck/SelErr pulses.
// Optional: FRAME_SWITCH_TPG_EN adds TpgSel and a counting test pattern.
module frame_switch
    import frame_pkg::*;
#(
    parameter int               PIX_W     = 8,
    parameter int               NUM_BUF   = 2,
    parameter logic [PIX_W-1:0] BLANK_VAL = '0,
    localparam int              BUF_IDX_W = buf_idx_w(NUM_BUF)
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NUM_BUF*PIX_W-1:0] BufData,
    input  logic                     PixValid,
    input  logic                     FrameEnd,
    input  logic                     SwapReq,
    input  logic [BUF_IDX_W-1:0]     SwapBuf,
    input  logic                     BlankReq,
`ifdef FRAME_SWITCH_TPG_EN
    input  logic                     TpgSel,
`endif
    output logic [PIX_W-1:0]         FrameIn,
    output logic                     FrameValid,
    output logic [BUF_IDX_W-1:0]     ActiveBuf,
    output logic                     Blanked,
    output logic                     SwapAck,
    output logic                     SelErr
);

    state_e               state, state_n;
    logic [BUF_IDX_W-1:0] target, target_n;
    logic [BUF_IDX_W-1:0] active_n;
    logic                 blanked_n;
    logic                 ack_n;
    logic                 bnd;
    logic                 legal;
    logic [PIX_W-1:0]     sel_pix;

    assign bnd   = PixValid & FrameEnd;
    assign legal = SwapReq && (int'(SwapBuf) < NUM_BUF);

`ifdef FRAME_SWITCH_TPG_EN
    logic             tpg_act;
    logic [PIX_W-1:0] tpg_cnt;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            tpg_act <= 1'b0;
            tpg_cnt <= '0;
        end else begin
            if (bnd) begin
                tpg_act <= TpgSel;
                tpg_cnt <= '0;
            end else if (PixValid) begin
                tpg_cnt <= tpg_cnt + 1'b1;
            end
        end
    end
`endif

    frame_pix_sel #(
        .PIX_W     (PIX_W),
        .NUM_BUF   (NUM_BUF),
        .BLANK_VAL (BLANK_VAL),
        .IDX_W     (BUF_IDX_W)
    ) u_sel (
        .buf_data (BufData),
        .sel      (ActiveBuf),
        .blanked  (Blanked),
`ifdef FRAME_SWITCH_TPG_EN
        .tpg_on   (tpg_act),
        .tpg_pix  (tpg_cnt),
`endif
        .pix      (sel_pix)
    );

    // Boundary resolution first, then requests act on the post-boundary
    // state, so a request landing on a boundary waits for the next one.
    always_comb begin
        state_n   = state;
        target_n  = target;
        active_n  = ActiveBuf;
        blanked_n = Blanked;
        ack_n     = 1'b0;
        if (bnd) begin
            if (state == ST_PEND_SWAP) begin
                state_n   = ST_RUN;
                active_n  = target;
                blanked_n = 1'b0;
                ack_n     = 1'b1;
            end else if (state == ST_PEND_BLANK) begin
                state_n   = ST_BLANK;
                blanked_n = 1'b1;
                ack_n     = 1'b1;
            end
        end
        if (BlankReq) begin
            if (state_n == ST_RUN || state_n == ST_PEND_SWAP) begin
                state_n = ST_PEND_BLANK;
            end
        end else if (legal) begin
            if (!(state_n == ST_RUN && SwapBuf == active_n)) begin
                state_n  = ST_PEND_SWAP;
                target_n = SwapBuf;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= ST_BLANK;
            target     <= '0;
            ActiveBuf  <= '0;
            Blanked    <= 1'b1;
            SwapAck    <= 1'b0;
            SelErr     <= 1'b0;
            FrameIn    <= BLANK_VAL;
            FrameValid <= 1'b0;
        end else begin
            state      <= state_n;
            target     <= target_n;
            ActiveBuf  <= active_n;
            Blanked    <= blanked_n;
            SwapAck    <= ack_n;
            SelErr     <= SwapReq && !legal;
            FrameValid <= PixValid;
            if (PixValid) begin
                FrameIn <= sel_pix;
            end
        end
    end

endmodule

// File: tb/tb_frame_switch.sv
// Directed bench for frame_switch (NUM_BUF=3, PIX_W=8).
// Table of per-cycle vectors plus hand sequences for reset and TPG.
module tb_frame_switch;

    logic        clk;
    logic        rst_n;
    logic [23:0] buf_data;
    logic        pix_valid;
    logic        frame_end;
    logic        swap_req;
    logic [1:0]  swap_buf;
    logic        blank_req;
    logic [7:0]  frame_in;
    logic        frame_valid;
    logic [1:0]  active_buf;
    logic        blanked;
    logic        swap_ack;
    logic        sel_err;
`ifdef FRAME_SWITCH_TPG_EN
    logic        tpg_sel;
`endif

    int tests;
    int failed;

    frame_switch #(
        .PIX_W     (8),
        .NUM_BUF   (3),
        .BLANK_VAL (8'h00)
    ) dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .BufData    (buf_data),
        .PixValid   (pix_valid),
        .FrameEnd   (frame_end),
        .SwapReq    (swap_req),
        .SwapBuf    (swap_buf),
        .BlankReq   (blank_req),
`ifdef FRAME_SWITCH_TPG_EN
        .TpgSel     (tpg_sel),
`endif
        .FrameIn    (frame_in),
        .FrameValid (frame_valid),
        .ActiveBuf  (active_buf),
        .Blanked    (blanked),
        .SwapAck    (swap_ack),
        .SelErr     (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pv;
        logic       fe;
        logic       sreq;
        logic [1:0] sbuf;
        logic       breq;
        logic [7:0] pix;
        logic       fv;
        logic [1:0] act;
        logic       blk;
        logic       ack;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic pv, fe, sreq, input logic [1:0] sbuf, input logic breq,
        input logic [7:0] pix, input logic fv, input logic [1:0] act,
        input logic blk, ack, err);
        vec_t v;
        v.pv = pv; v.fe = fe; v.sreq = sreq; v.sbuf = sbuf; v.breq = breq;
        v.pix = pix; v.fv = fv; v.act = act; v.blk = blk;
        v.ack = ack; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic step(input logic pv, fe, sreq, input logic [1:0] sb,
                        input logic br);
        pix_valid = pv;
        frame_end = fe;
        swap_req  = sreq;
        swap_buf  = sb;
        blank_req = br;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst_n     = 1'b0;
        buf_data  = {8'hC2, 8'hB1, 8'hA0};
        pix_valid = 1'b0;
        frame_end = 1'b0;
        swap_req  = 1'b0;
        swap_buf  = 2'd0;
        blank_req = 1'b0;
`ifdef FRAME_SWITCH_TPG_EN
        tpg_sel   = 1'b0;
`endif

        //      pv fe sr sb br  pix   fv act blk ack err
        // swap to buffer 1 mid-frame
        vecs.push_back(mk(1,0,0,0,0, 8'h00,1,0,1,0,0));
        vecs.push_back(mk(1,1,0,0,0, 8'h00,1,0,1,0,0));
        vecs.push_back(mk(1,0,1,1,0, 8'h00,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 8'h00,1,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00,0,0,1,0,0));
        vecs.push_back(mk(1,1,0,0,0, 8'h00,1,1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0, 8'hB1,1,1,0,0,0));
        vecs.push_back(mk(1,0,1,1,0, 8'hB1,1,1,0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 8'hB1,1,1,0,0,0));
        // blank from RUN
        vecs.push_back(mk(1,0,0,0,1, 8'hB1,1,1,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 8'hB1,1,1,0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 8'hB1,1,1,1,1,0));
        vecs.push_back(mk(1,0,0,0,0, 8'h00,1,1,1,0,0));
        vecs.push_back(mk(1,0,0,0,1, 8'h00,1,1,1,0,0));
        // swap to 2, then blank+swap collision
        vecs.push_back(mk(1,0,1,2,0, 8'h00,1,1,1,0,0));
        vecs.push_back(mk(1,1,0,0,0, 8'h00,1,2,0,1,0));
        vecs.push_back(mk(1,0,0,0,0, 8'hC2,1,2,0,0,0));
        vecs.push_back(mk(1,0,1,0,1, 8'hC2,1,2,0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 8'hC2,1,2,1,1,0));
        vecs.push_back(mk(1,0,0,0,0, 8'h00,1,2,1,0,0));
        // swap request on the boundary waits one frame
        vecs.push_back(mk(1,1,1,0,0, 8'h00,1,2,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 8'h00,1,2,1,0,0));
        vecs.push_back(mk(1,1,0,0,0, 8'h00,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0, 8'hA0,1,0,0,0,0));
        // illegal index
        vecs.push_back(mk(1,0,1,3,0, 8'hA0,1,0,0,0,1));
        vecs.push_back(mk(1,1,0,0,0, 8'hA0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 8'hA0,1,0,0,0,0));
        // pending blank overwritten by a swap
        vecs.push_back(mk(1,0,0,0,1, 8'hA0,1,0,0,0,0));
        vecs.push_back(mk(1,0,1,1,0, 8'hA0,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 8'hA0,1,1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0, 8'hB1,1,1,0,0,0));

        // reset held 3 cycles with pixels flowing
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0);
            chk("rst_pix", i, 32'(frame_in), 32'h00);
            chk("rst_fv",  i, 32'(frame_valid), 32'h0);
            chk("rst_blk", i, 32'(blanked), 32'h1);
            chk("rst_act", i, 32'(active_buf), 32'h0);
        end
        chk("rst_ack", 0, 32'(swap_ack), 32'h0);
        chk("rst_err", 0, 32'(sel_err), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].pv, vecs[i].fe, vecs[i].sreq, vecs[i].sbuf,
                 vecs[i].breq);
            chk("pix", i, 32'(frame_in),    32'(vecs[i].pix));
            chk("fv",  i, 32'(frame_valid), 32'(vecs[i].fv));
            chk("act", i, 32'(active_buf),  32'(vecs[i].act));
            chk("blk", i, 32'(blanked),     32'(vecs[i].blk));
            chk("ack", i, 32'(swap_ack),    32'(vecs[i].ack));
            chk("err", i, 32'(sel_err),     32'(vecs[i].err));
        end

        // reset discards a pending swap
        step(1, 0, 1, 2, 0);
        rst_n = 1'b0;
        step(1, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1, 1, 0, 0, 0);
        chk("rp_ack", 0, 32'(swap_ack), 32'h0);
        chk("rp_act", 0, 32'(active_buf), 32'h0);
        chk("rp_blk", 0, 32'(blanked), 32'h1);
        step(1, 0, 0, 0, 0);
        chk("rp_pix", 0, 32'(frame_in), 32'h00);

`ifdef FRAME_SWITCH_TPG_EN
        tpg_sel = 1'b1;
        step(1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("tpg_ack", 0, 32'(swap_ack), 32'h1);
        step(1, 0, 0, 0, 0);
        chk("tpg_pix", 0, 32'(frame_in), 32'h00);
        step(1, 0, 0, 0, 0);
        chk("tpg_pix", 1, 32'(frame_in), 32'h01);
        step(1, 0, 0, 0, 0);
        chk("tpg_pix", 2, 32'(frame_in), 32'h02);
        step(1, 1, 0, 0, 0);
        chk("tpg_pix", 3, 32'(frame_in), 32'h03);
        step(1, 0, 0, 0, 0);
        chk("tpg_pix", 4, 32'(frame_in), 32'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
